// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM duty sequencing datapath.
package pwm_pkg;

    localparam int unsigned DUTY_W = 4;
    localparam logic [DUTY_W-1:0] DUTY_MAX = 4'd9;
    localparam int unsigned STEP_W = 8;

    typedef enum logic [1:0] {
        StHold = 2'd0,
        StUp   = 2'd1,
        StDown = 2'd2
    } seq_state_e;

    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] code);
        return (code > DUTY_MAX) ? DUTY_MAX : code;
    endfunction

endpackage

// File: rtl/pwm_duty_sequencer_if.sv
// Control/status bundle between the switch side and the sequencer.
interface pwm_duty_sequencer_if #(
    parameter int unsigned DATA = 8
);
    import pwm_pkg::*;

    logic              en;
    logic [DUTY_W-1:0] sw;
    logic [DATA-1:0]   counter;
    logic [DUTY_W-1:0] duty;
    logic              period_tick;
    logic              busy;
    logic              ramp_done;

    modport master (
        output en,
        output sw,
        input  counter,
        input  duty,
        input  period_tick,
        input  busy,
        input  ramp_done
    );

    modport slave (
        input  en,
        input  sw,
        output counter,
        output duty,
        output period_tick,
        output busy,
        output ramp_done
    );

endinterface

// File: rtl/pwm_period_counter.sv
// Free-running PWM period counter with wrap detect and registered period tick.
module pwm_period_counter #(
    parameter int unsigned DATA = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    output logic [DATA-1:0] counter,
    output logic            wrap,
    output logic            period_tick
);

    localparam logic [DATA-1:0] CNT_MAX = '1;

    logic [DATA-1:0] count_q;
    logic            tick_q;

    // High on the edge that takes the counter MAX -> 0.
    assign wrap = en && (count_q == CNT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else if (!en) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_q + DATA'(1);
            tick_q  <= wrap;
        end
    end

    assign counter     = count_q;
    assign period_tick = tick_q;

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Soft-start/soft-stop duty sequencer: syncs the switch request and ramps duty per period.
module pwm_duty_sequencer
    import pwm_pkg::*;
#(
    parameter int unsigned DATA         = 8,
    parameter int unsigned STEP_PERIODS = 4,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input logic                    clk,
    input logic                    rst,
    pwm_duty_sequencer_if.slave    bus
);

    logic [SYNC_STAGES-1:0][DUTY_W-1:0] sync_q;
    logic [DUTY_W-1:0]                  req;
    logic                               boundary;

    seq_state_e        state_q;
    logic [DUTY_W-1:0] duty_q;
    logic [DUTY_W-1:0] target_q;
    logic [STEP_W-1:0] step_q;
    logic              busy_q;
    logic              done_q;

    logic [DUTY_W-1:0] duty_step;
    logic              step_last;
    logic              reverse;

    // The sync chain keeps running while disabled so the request is settled on re-enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sw};
        end
    end

    assign req = clamp_duty(sync_q[SYNC_STAGES-1]);

    pwm_period_counter #(
        .DATA (DATA)
    ) u_period_counter (
        .clk         (clk),
        .rst         (rst),
        .en          (bus.en),
        .counter     (bus.counter),
        .wrap        (boundary),
        .period_tick (bus.period_tick)
    );

    always_comb begin
        duty_step = (state_q == StDown) ? duty_q - 4'd1 : duty_q + 4'd1;
        step_last = (step_q == STEP_W'(STEP_PERIODS - 1));
        reverse   = (state_q == StUp) ? (req < duty_q) : (req > duty_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StHold;
            duty_q   <= '0;
            target_q <= '0;
            step_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (!bus.en) begin
            state_q  <= StHold;
            duty_q   <= '0;
            target_q <= '0;
            step_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (boundary) begin
                target_q <= req;
                case (state_q)
                    StHold: begin
                        step_q <= '0;
                        busy_q <= (req != duty_q);
                        if (req > duty_q) begin
                            state_q <= StUp;
                        end else if (req < duty_q) begin
                            state_q <= StDown;
                        end
                    end
                    StUp, StDown: begin
                        if (req == duty_q) begin
                            state_q <= StHold;
                            step_q  <= '0;
                            busy_q  <= 1'b0;
                        end else if (reverse) begin
                            // Turn around without stepping on this boundary.
                            state_q <= (state_q == StUp) ? StDown : StUp;
                            step_q  <= '0;
                            busy_q  <= 1'b1;
                        end else if (step_last) begin
                            step_q <= '0;
                            duty_q <= duty_step;
                            busy_q <= (duty_step != req);
                            if (duty_step == req) begin
                                state_q <= StHold;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            step_q <= step_q + STEP_W'(1);
                            busy_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StHold;
                        step_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.duty      = duty_q;
    assign bus.busy      = busy_q;
    assign bus.ramp_done = done_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed plus randomized bench for pwm_duty_sequencer against a period-level reference model.
module tb_pwm_duty_sequencer;

    localparam int unsigned DATA         = 8;
    localparam int unsigned STEP_PERIODS = 2;
    localparam int unsigned SYNC_STAGES  = 2;
    localparam int          PERIOD       = 1 << DATA;
    localparam int          CNT_MAX      = PERIOD - 1;

    logic clk;
    logic rst;

    pwm_duty_sequencer_if #(.DATA(DATA)) bus ();

    pwm_duty_sequencer #(
        .DATA         (DATA),
        .STEP_PERIODS (STEP_PERIODS),
        .SYNC_STAGES  (SYNC_STAGES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: position within the period, latched target, applied duty,
    // ramp direction (+1/-1/0) and whole periods spent toward the next step.
    int m_cnt, m_duty, m_target, m_dir, m_periods;
    bit m_tick, m_done;
    int sw_hist[$];

    int rd_pulses;
    int max_duty;
    bit busy_seen;

    task automatic model_reset();
        m_cnt = 0; m_duty = 0; m_target = 0; m_dir = 0; m_periods = 0;
        m_tick = 0; m_done = 0;
        sw_hist.delete();
        for (int i = 0; i < int'(SYNC_STAGES); i++) sw_hist.push_back(0);
    endtask

    task automatic model_edge();
        int used;
        int t;
        int want;
        used = sw_hist.pop_front();
        sw_hist.push_back(int'(bus.sw));
        m_tick = 0;
        m_done = 0;
        if (!bus.en) begin
            m_cnt = 0; m_duty = 0; m_target = 0; m_dir = 0; m_periods = 0;
            return;
        end
        if (m_cnt != CNT_MAX) begin
            m_cnt = m_cnt + 1;
            return;
        end
        m_cnt    = 0;
        m_tick   = 1;
        t        = (used > 9) ? 9 : used;
        m_target = t;
        want     = (t > m_duty) ? 1 : ((t < m_duty) ? -1 : 0);
        if (want == 0) begin
            m_dir = 0; m_periods = 0;
        end else if (want != m_dir) begin
            m_dir = want; m_periods = 0;
        end else if (m_periods == int'(STEP_PERIODS) - 1) begin
            m_periods = 0;
            m_duty    = m_duty + m_dir;
            if (m_duty == t) begin
                m_done = 1;
                m_dir  = 0;
            end
        end else begin
            m_periods = m_periods + 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_tests++;
        assert (got === 32'(exp)) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".counter"}, 32'(bus.counter), m_cnt);
        chk({tag, ".duty"}, 32'(bus.duty), m_duty);
        chk({tag, ".period_tick"}, 32'(bus.period_tick), int'(m_tick));
        chk({tag, ".busy"}, 32'(bus.busy), (m_duty != m_target) ? 1 : 0);
        chk({tag, ".ramp_done"}, 32'(bus.ramp_done), int'(m_done));
        if (bus.ramp_done === 1'b1) rd_pulses++;
        if (int'(bus.duty) > max_duty) max_duty = int'(bus.duty);
        if (bus.busy === 1'b1) busy_seen = 1'b1;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        int n;
        rst    = 1'b1;
        bus.en = 1'b0;
        bus.sw = 4'd0;
        model_reset();
        #1 rst = 1'b0;
        #1;
        chk("por.counter", 32'(bus.counter), 0);
        chk("por.duty", 32'(bus.duty), 0);
        chk("por.busy", 32'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b1;

        // Ramp toward 5, then assert reset asynchronously once duty reaches 3.
        bus.en = 1'b1;
        bus.sw = 4'd5;
        n = 0;
        while (m_duty != 3 && n < 4000) begin cycle("rst_ramp"); n++; end
        chk("rst_ramp.reach3", 32'(bus.duty), 3);
        #2 rst = 1'b0;
        #1;
        chk("async_rst.counter", 32'(bus.counter), 0);
        chk("async_rst.duty", 32'(bus.duty), 0);
        chk("async_rst.busy", 32'(bus.busy), 0);
        chk("async_rst.period_tick", 32'(bus.period_tick), 0);
        chk("async_rst.ramp_done", 32'(bus.ramp_done), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_all("rst_hold");
        rst    = 1'b1;
        bus.en = 1'b0;
        repeat (20) cycle("post_rst_idle");

        // Ramp up to 3 with one ramp_done pulse.
        bus.sw    = 4'd3;
        bus.en    = 1'b1;
        rd_pulses = 0;
        n = 0;
        while (!(m_duty == 3 && m_target == 3) && n < 4000) begin cycle("ramp_up"); n++; end
        repeat (600) cycle("ramp_up_settle");
        chk("ramp_up.duty", 32'(bus.duty), 3);
        chk("ramp_up.done_pulses", 32'(rd_pulses), 1);

        // Out-of-range request is clamped to 9.
        bus.sw    = 4'd12;
        rd_pulses = 0;
        max_duty  = 0;
        n = 0;
        while (m_duty != 9 && n < 6000) begin cycle("clamp"); n++; end
        repeat (600) cycle("clamp_settle");
        chk("clamp.duty", 32'(bus.duty), 9);
        chk("clamp.max_duty", 32'(max_duty), 9);
        chk("clamp.done_pulses", 32'(rd_pulses), 1);

        // Reversal: ramp up toward 9, request 2 at duty 6.
        bus.en = 1'b0;
        cycle("rev_dis");
        bus.en = 1'b1;
        bus.sw = 4'd9;
        n = 0;
        while (m_duty != 6 && n < 5000) begin cycle("rev_up"); n++; end
        bus.sw = 4'd2;
        n = 0;
        while (m_cnt != CNT_MAX && n < 300) begin cycle("rev_wait"); n++; end
        chk("rev.pre_boundary_duty", 32'(bus.duty), 6);
        chk("rev.pre_boundary_busy", 32'(bus.busy), 1);
        cycle("rev_boundary");
        chk("rev.no_step", 32'(bus.duty), 6);
        rd_pulses = 0;
        n = 0;
        while (!(m_duty == 2 && m_dir == 0) && n < 5000) begin cycle("rev_down"); n++; end
        repeat (300) cycle("rev_settle");
        chk("rev.duty", 32'(bus.duty), 2);
        chk("rev.done_pulses", 32'(rd_pulses), 1);

        // Disable mid-ramp, then re-enable for a soft start.
        bus.sw = 4'd9;
        n = 0;
        while (m_duty != 4 && n < 3000) begin cycle("dis_up"); n++; end
        bus.en = 1'b0;
        cycle("dis");
        chk("dis.counter", 32'(bus.counter), 0);
        chk("dis.duty", 32'(bus.duty), 0);
        chk("dis.busy", 32'(bus.busy), 0);
        bus.en = 1'b1;
        n = 0;
        while (bus.period_tick !== 1'b1 && n < 400) begin cycle("reen"); n++; end
        chk("reen.first_tick_latency", 32'(n), 256);
        n = 0;
        while (m_duty != 1 && n < 2000) begin cycle("reen_ramp"); n++; end
        chk("reen.duty", 32'(bus.duty), 1);

        // Short glitch on sw between boundaries is ignored.
        bus.sw = 4'd2;
        n = 0;
        while (!(m_duty == 2 && m_dir == 0) && n < 3000) begin cycle("glitch_prep"); n++; end
        n = 0;
        while (m_cnt != 100 && n < 300) begin cycle("glitch_align"); n++; end
        busy_seen = 1'b0;
        bus.sw = 4'd7;
        repeat (3) cycle("glitch_on");
        bus.sw = 4'd2;
        repeat (600) cycle("glitch_off");
        chk("glitch.busy_seen", 32'(busy_seen), 0);
        chk("glitch.duty", 32'(bus.duty), 2);

        // Randomized requests and enable toggling.
        for (int s = 0; s < 20; s++) begin
            bus.sw = 4'($urandom_range(0, 15));
            bus.en = ($urandom_range(0, 5) != 0);
            n = $urandom_range(50, 1500);
            repeat (n) cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
